// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control FSM (Moore) with per-memory-state wait counter.
// Define MC_CONTROL_JUMP_EN to decode opcode 000010 (j) into the JUMP state.
module mc_control_fsm #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CONTROL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [2:0] alu_op;
    logic [2:0] funct_op;
    logic       funct_ok;
    logic       last;

    assign last    = (wait_cnt == WAIT_LAST);
    assign state_o = state;

    always_comb begin
        funct_ok = 1'b1;
        funct_op = 3'b010;
        case (funct)
            6'b100000: funct_op = 3'b010;
            6'b100010: funct_op = 3'b110;
            6'b100100: funct_op = 3'b000;
            6'b100101: funct_op = 3'b001;
            6'b101010: funct_op = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end

    // The counter restarts on every state change, so it only accumulates in memory states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            wait_cnt <= 4'd0;
            alu_op   <= 3'b000;
        end else begin
            state    <= state_next;
            wait_cnt <= (state_next != state) ? 4'd0 : wait_cnt + 4'd1;
            if (state == S_DECODE)
                alu_op <= funct_op;
        end
    end

    always_comb begin
        state_next  = state;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                if (last) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADR;
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            state_next = S_EXECUTE;
                        end else begin
                            illegal_op = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_next = S_BRANCH;
                    OP_ADDI: state_next = S_ADDI_EX;
`ifdef MC_CONTROL_JUMP_EN
                    OP_J:    state_next = S_JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
                state_next  = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord = 1'b1;
                if (last)
                    state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord = 1'b1;
                if (last) begin
                    mem_write  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = alu_op;
                state_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en       = zero;
                state_next  = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
                state_next  = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JUMP: begin
`ifdef MC_CONTROL_JUMP_EN
                pc_src = 2'b10;
                pc_en  = 1'b1;
`endif
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: three instances (MEM_WAIT 0, 2, 3) driven from a vector table
// through a scoreboard queue, plus a hand-written asynchronous reset during a store.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        int         inst;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [3:0] st;
        logic [2:0] alu;
        logic [3:0] strb;
    } vec_t;

    typedef struct {
        int    inst;
        int    idx;
        outs_t e;
    } sb_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    // Strobe patterns {ir_write, pc_en, mem_write, illegal_op}
    localparam logic [3:0] S0 = 4'b0000;
    localparam logic [3:0] SF = 4'b1100;
    localparam logic [3:0] SW_ = 4'b0010;
    localparam logic [3:0] SI = 4'b0001;
    localparam logic [3:0] SP = 4'b0100;

    logic       clk;
    logic       rstn [3];
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    outs_t      o [3];

    vec_t tbl[$];
    sb_t  sbq[$];
    int   nvec;
    int   nmis;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mc_control_fsm #(.MEM_WAIT(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .clk        (clk),
            .rst_n      (rstn[g]),
            .opcode     (opcode),
            .funct      (funct),
            .zero       (zero),
            .iord       (o[g].iord),
            .mem_write  (o[g].mem_write),
            .ir_write   (o[g].ir_write),
            .reg_dst    (o[g].reg_dst),
            .mem_to_reg (o[g].mem_to_reg),
            .reg_write  (o[g].reg_write),
            .alu_src_a  (o[g].alu_src_a),
            .alu_src_b  (o[g].alu_src_b),
            .alu_control(o[g].alu_control),
            .pc_src     (o[g].pc_src),
            .pc_en      (o[g].pc_en),
            .illegal_op (o[g].illegal_op),
            .state_o    (o[g].state)
        );
    end

    // Per-state selects and fixed strobes; ALU code and conditional strobes come from the table.
    function automatic outs_t expected(logic [3:0] st, logic [2:0] alu, logic [3:0] strb);
        outs_t e;
        e = '0;
        e.state = st;
        e.alu_control = alu;
        {e.ir_write, e.pc_en, e.mem_write, e.illegal_op} = strb;
        case (st)
            4'd1:  e.alu_src_b = 2'b01;
            4'd2:  e.alu_src_b = 2'b11;
            4'd3:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd4:  e.iord = 1'b1;
            4'd5:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
            4'd6:  e.iord = 1'b1;
            4'd7:  e.alu_src_a = 1'b1;
            4'd8:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
            4'd9:  begin e.alu_src_a = 1'b1; e.pc_src = 2'b01; end
            4'd10: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            4'd11: e.reg_write = 1'b1;
            4'd12: e.pc_src = 2'b10;
            default: ;
        endcase
        return e;
    endfunction

    function automatic void add(int inst, logic rst, logic [5:0] op, logic [5:0] fn, logic z,
                                logic [3:0] st, logic [2:0] alu, logic [3:0] strb);
        vec_t v;
        v = '{inst, rst, op, fn, z, st, alu, strb};
        tbl.push_back(v);
    endfunction

    // One R-type instruction on instance 0 with MEM_WAIT=0.
    function automatic void add_rtype(logic [5:0] fn, logic [2:0] alu);
        add(0, 1, RT, fn, 0, 4'd1, 3'b010, SF);
        add(0, 1, RT, fn, 0, 4'd2, 3'b010, S0);
        add(0, 1, RT, fn, 0, 4'd7, alu,    S0);
        add(0, 1, RT, fn, 0, 4'd8, 3'b000, S0);
    endfunction

    task automatic applyStimulus(input vec_t v, input int idx);
        sb_t s;
        rstn[v.inst] = v.rst;
        opcode = v.op;
        funct  = v.fn;
        zero   = v.z;
        s.inst = v.inst;
        s.idx  = idx;
        s.e    = expected(v.st, v.alu, v.strb);
        sbq.push_back(s);
    endtask

    task automatic checkOutput();
        sb_t s;
        nvec++;
        if (sbq.size() == 0) begin
            nmis++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, required 1");
        end else begin
            s = sbq.pop_front();
            if (o[s.inst] !== s.e) begin
                nmis++;
                $display("[TB] FAIL vec%0d dut%0d: got %h (state %0d) required %h (state %0d)",
                         s.idx, s.inst, o[s.inst], o[s.inst].state, s.e, s.e.state);
            end
        end
    endtask

    task automatic checkSig(input string name, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin
            nmis++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    initial begin
        clk    = 1'b0;
        nvec   = 0;
        nmis   = 0;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        for (int i = 0; i < 3; i++) rstn[i] = 1'b0;

        // Instance 0, MEM_WAIT=0: reset, then every instruction class
        for (int i = 0; i < 3; i++) add(0, 0, LW, 0, 0, 4'd0, 3'b000, S0);
        add(0, 1, LW, 0, 0, 4'd0, 3'b000, S0);
        add(0, 1, LW, 0, 0, 4'd1, 3'b010, SF);
        add(0, 1, LW, 0, 0, 4'd2, 3'b010, S0);
        add(0, 1, LW, 0, 0, 4'd3, 3'b010, S0);
        add(0, 1, LW, 0, 0, 4'd4, 3'b000, S0);
        add(0, 1, LW, 0, 0, 4'd5, 3'b000, S0);
        add(0, 1, SW, 0, 0, 4'd1, 3'b010, SF);
        add(0, 1, SW, 0, 0, 4'd2, 3'b010, S0);
        add(0, 1, SW, 0, 0, 4'd3, 3'b010, S0);
        add(0, 1, SW, 0, 0, 4'd6, 3'b000, SW_);
        add_rtype(6'b100010, 3'b110);
        add_rtype(6'b100000, 3'b010);
        add_rtype(6'b100100, 3'b000);
        add_rtype(6'b100101, 3'b001);
        add_rtype(6'b101010, 3'b111);
        add(0, 1, RT, 6'b111111, 0, 4'd1, 3'b010, SF);
        add(0, 1, RT, 6'b111111, 0, 4'd2, 3'b010, SI);
        add(0, 1, BAD, 0, 0, 4'd1, 3'b010, SF);
        add(0, 1, BAD, 0, 0, 4'd2, 3'b010, SI);
        add(0, 1, ADDI, 0, 0, 4'd1, 3'b010, SF);
        add(0, 1, ADDI, 0, 0, 4'd2, 3'b010, S0);
        add(0, 1, ADDI, 0, 0, 4'd10, 3'b010, S0);
        add(0, 1, ADDI, 0, 0, 4'd11, 3'b000, S0);
        add(0, 1, BEQ, 0, 1, 4'd1, 3'b010, SF);
        add(0, 1, BEQ, 0, 1, 4'd2, 3'b010, S0);
        add(0, 1, BEQ, 0, 1, 4'd9, 3'b110, SP);
        add(0, 1, BEQ, 0, 0, 4'd1, 3'b010, SF);
        add(0, 1, BEQ, 0, 0, 4'd2, 3'b010, S0);
        add(0, 1, BEQ, 0, 0, 4'd9, 3'b110, S0);
        add(0, 1, JMP, 0, 0, 4'd1, 3'b010, SF);
`ifdef MC_CONTROL_JUMP_EN
        add(0, 1, JMP, 0, 0, 4'd2, 3'b010, S0);
        add(0, 1, JMP, 0, 0, 4'd12, 3'b000, SP);
`else
        add(0, 1, JMP, 0, 0, 4'd2, 3'b010, SI);
`endif
        add(0, 1, LW, 0, 0, 4'd1, 3'b010, SF);

        // Instance 1, MEM_WAIT=2: lw with stretched FETCH and MEM_READ
        add(1, 0, LW, 0, 0, 4'd0, 3'b000, S0);
        add(1, 1, LW, 0, 0, 4'd0, 3'b000, S0);
        add(1, 1, LW, 0, 0, 4'd1, 3'b010, S0);
        add(1, 1, LW, 0, 0, 4'd1, 3'b010, S0);
        add(1, 1, LW, 0, 0, 4'd1, 3'b010, SF);
        add(1, 1, LW, 0, 0, 4'd2, 3'b010, S0);
        add(1, 1, LW, 0, 0, 4'd3, 3'b010, S0);
        for (int i = 0; i < 3; i++) add(1, 1, LW, 0, 0, 4'd4, 3'b000, S0);
        add(1, 1, LW, 0, 0, 4'd5, 3'b000, S0);
        add(1, 1, LW, 0, 0, 4'd1, 3'b010, S0);

        // Instance 2, MEM_WAIT=3: sw up to the first MEM_WRITE cycle
        add(2, 0, SW, 0, 0, 4'd0, 3'b000, S0);
        add(2, 1, SW, 0, 0, 4'd0, 3'b000, S0);
        for (int i = 0; i < 3; i++) add(2, 1, SW, 0, 0, 4'd1, 3'b010, S0);
        add(2, 1, SW, 0, 0, 4'd1, 3'b010, SF);
        add(2, 1, SW, 0, 0, 4'd2, 3'b010, S0);
        add(2, 1, SW, 0, 0, 4'd3, 3'b010, S0);
        add(2, 1, SW, 0, 0, 4'd6, 3'b000, S0);

        @(posedge clk);
        #1;
        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k], k);
            @(negedge clk);
            checkOutput();
            @(posedge clk);
            #1;
        end

        // Second MEM_WRITE cycle of instance 2, then asynchronous reset mid-cycle
        checkSig("sw_wr2_state", 32'(o[2].state), 32'd6);
        checkSig("sw_wr2_mem_write", 32'(o[2].mem_write), 32'd0);
        #2;
        rstn[2] = 1'b0;
        #1;
        checkSig("rst_mid_state", 32'(o[2].state), 32'd0);
        checkSig("rst_mid_mem_write", 32'(o[2].mem_write), 32'd0);
        checkSig("rst_mid_iord", 32'(o[2].iord), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkSig("rst_hold_mem_write", 32'(o[2].mem_write), 32'd0);
            checkSig("rst_hold_state", 32'(o[2].state), 32'd0);
        end
        @(posedge clk);
        #1;
        rstn[2] = 1'b1;
        @(negedge clk);
        checkSig("rel_state_reset", 32'(o[2].state), 32'd0);
        @(negedge clk);
        checkSig("rel_state_fetch", 32'(o[2].state), 32'd1);
        checkSig("rel_ir_write_first", 32'(o[2].ir_write), 32'd0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        checkSig("rel_ir_write_last", 32'(o[2].ir_write), 32'd1);
        checkSig("rel_state_fetch_last", 32'(o[2].state), 32'd1);
        checkSig("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle controller for the MIPS-subset datapath. It is the producer side of the control interface that the ALU, muxes and adders consume.
- Decodes opcode/funct from the instruction register and sequences a Moore FSM.
- Drives the 3-bit ALU operation code, mux selects, register/memory write strobes and PC enable, one instruction per multi-cycle pass.

Parameters:
- MEM_WAIT, 0, extra wait cycles spent in each memory-access state (FETCH, MEM_READ, MEM_WRITE); range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  instr[31:26] from instruction register.
- funct  input  6  instr[5:0] from instruction register.
- zero  input  1  ALU zero flag.
- iord  output  1  memory address select: 0=PC, 1=ALU result register.
- mem_write  output  1  data memory write strobe.
- ir_write  output  1  instruction register load.
- reg_dst  output  1  write register select: 0=rt, 1=rd.
- mem_to_reg  output  1  register write data: 0=ALU result, 1=memory data.
- reg_write  output  1  register file write strobe.
- alu_src_a  output  1  0=PC, 1=register A.
- alu_src_b  output  2  00=register B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm shifted left 2.
- alu_control  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- pc_src  output  2  00=ALU result, 01=ALU output register, 10=jump target.
- pc_en  output  1  PC load.
- illegal_op  output  1  one-cycle pulse on an unsupported instruction.
- state_o  output  4  current state, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous): state=RESET (0). All outputs 0. The wait counter and the captured alu op are 0.
- After rst_n deasserts: one cycle in RESET with all outputs 0, then FETCH.
- State encoding: RESET 0, FETCH 1, DECODE 2, MEM_ADR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, ADDI_EX 10, ADDI_WB 11, JUMP 12. Codes 13-15 go to FETCH on the next edge.
- Outputs are Moore-decoded from state. Exception: pc_en in BRANCH = zero. Any output not listed for a state is 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00. ir_write=1 and pc_en=1 only in the last wait cycle. Next: DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010. Capture the funct-derived ALU op.
  - opcode 100011 (lw) or 101011 (sw) -> MEM_ADR.
  - opcode 000000 with a supported funct -> EXECUTE.
  - opcode 000100 (beq) -> BRANCH.
  - opcode 001000 (addi) -> ADDI_EX.
  - opcode 000010 (j) -> JUMP, only when the macro is enabled.
  - Anything else: illegal_op=1 for this cycle, next state FETCH, no state written.
- Supported funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
- MEM_ADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: iord=1, then MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEM_WRITE: iord=1, mem_write=1 only in the last wait cycle, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control=captured op, then ALU_WB.
- ALU_WB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_src=01, pc_en=zero, then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_control=010, then ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JUMP: pc_src=10, pc_en=1, then FETCH.
- Wait counter:
  - Loads 0 on entry to a memory state and increments each cycle.
  - The state exits when counter==MEM_WAIT, so each memory state lasts MEM_WAIT+1 cycles.
  - Mux selects are held for the whole state; strobes fire only in the final cycle.
  - Non-memory states always last 1 cycle.
- Latency with MEM_WAIT=0 (cycles):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Reset mid-instruction: returns immediately to RESET and all strobes drop the same instant. No partial write completes afterward.

Optional Feature:
- Macro: MC_CONTROL_JUMP_EN.
- Defined: opcode 000010 decodes to JUMP (pc_src=10, pc_en=1).
- Undefined: state 12 is never entered. opcode 000010 is treated as illegal (illegal_op pulse, return to FETCH), and pc_src never takes value 10.

Test Plan:
- Reset: hold rst_n=0 three cycles, release -> all outputs 0; state_o 0 for one cycle, then 1 with ir_write=1, pc_en=1, alu_src_b=01, alu_control=010.
- lw, MEM_WAIT=0: opcode 100011 -> states 1,2,3,4,5 over 5 cycles; in state 5 reg_write=1, mem_to_reg=1, reg_dst=0. Repeat with MEM_WAIT=2: FETCH and MEM_READ each last 3 cycles; ir_write high only in the 3rd FETCH cycle.
- R-type: opcode 000000, funct 100010 -> EXECUTE with alu_control=110, then ALU_WB with reg_dst=1, reg_write=1. funct 111111 -> illegal_op=1 in DECODE, next state 1, no reg_write.
- beq: opcode 000100 with zero=1 in BRANCH -> pc_en=1, pc_src=01, alu_control=110. With zero=0 -> pc_en=0. Both return to FETCH.
- Reset mid-op: sw with MEM_WAIT=3, pull rst_n low in the 2nd MEM_WRITE cycle -> mem_write stays 0 and state_o=0 immediately; the next FETCH starts after release.
- Jump: opcode 000010 -> with MC_CONTROL_JUMP_EN: state 12, pc_src=10, pc_en=1. Without: illegal_op=1 in DECODE, next state FETCH.
